// File: rtl/ahb_lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_pkg
// Shared AHB-Lite encodings for the interconnect:
//   - HTRANS transfer-type encodings
//   - HRESP response encodings
//   - default-slave FSM state type
//   - htrans_active(): true for NONSEQ/SEQ, the transfers a slave must answer
// ---------------------------------------------------------------------------
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OKAY = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  function automatic logic htrans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Answers transfers to unmapped slots. Active transfers (NONSEQ/SEQ) get the
// two-cycle AHB ERROR response; IDLE/BUSY get a zero-wait OKAY. Every ERROR
// start is logged in a saturating counter together with its address.
// Ports:
//   i_clk, i_rst     bus clock, asynchronous active-high reset
//   i_hready         bus-wide HREADY (address phase accepted when 1)
//   i_unmapped       address-phase decode hit no populated slot
//   i_active         address-phase HTRANS is NONSEQ/SEQ
//   i_haddr          address-phase HADDR (captured on an error)
//   i_err_clr        synchronous clear of the error log (wins over a new error)
//   o_hready/o_hresp data-phase response of the default slave
//   o_err_count      saturating decode-error count
//   o_err_addr       address of the most recent decode error
// ---------------------------------------------------------------------------
module ahb_default_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_hready,
  input  logic                    i_unmapped,
  input  logic                    i_active,
  input  logic [ADDR_WIDTH-1:0]   i_haddr,
  input  logic                    i_err_clr,
  output logic                    o_hready,
  output logic                    o_hresp,
  output logic [ERRCNT_WIDTH-1:0] o_err_count,
  output logic [ADDR_WIDTH-1:0]   o_err_addr
);

  ds_state_e               r_state;
  ds_state_e               w_state_next;
  logic                    w_err_event;
  logic [ERRCNT_WIDTH-1:0] r_err_count;
  logic [ADDR_WIDTH-1:0]   r_err_addr;

  // State register of the default-slave response FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= DS_OKAY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, error event and data-phase response; outputs depend on state only.
  always_comb begin
    w_state_next = r_state;
    w_err_event  = 1'b0;
    o_hready     = 1'b1;
    o_hresp      = HRESP_OKAY;
    case (r_state)
      DS_OKAY: begin
        if (i_hready && i_unmapped && i_active) begin
          w_state_next = DS_ERR1;
          w_err_event  = 1'b1;
        end else begin
          w_state_next = DS_OKAY;
        end
      end
      DS_ERR1: begin
        // First ERROR cycle stalls the master; second cycle always follows.
        o_hready     = 1'b0;
        o_hresp      = HRESP_ERROR;
        w_state_next = DS_ERR2;
      end
      DS_ERR2: begin
        // HREADY is high here, so the pipelined next access is accepted now.
        o_hresp = HRESP_ERROR;
        if (i_hready && i_unmapped && i_active) begin
          w_state_next = DS_ERR1;
          w_err_event  = 1'b1;
        end else begin
          w_state_next = DS_OKAY;
        end
      end
      default: begin
        w_state_next = DS_OKAY;
      end
    endcase
  end

  // Error log: clear has priority over a same-cycle error; the count saturates.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_count <= {ERRCNT_WIDTH{1'b0}};
      r_err_addr  <= {ADDR_WIDTH{1'b0}};
    end else if (i_err_clr) begin
      r_err_count <= {ERRCNT_WIDTH{1'b0}};
      r_err_addr  <= {ADDR_WIDTH{1'b0}};
    end else if (w_err_event) begin
      if (r_err_count != {ERRCNT_WIDTH{1'b1}}) begin
        r_err_count <= r_err_count + ERRCNT_WIDTH'(1);
      end
      r_err_addr <= i_haddr;
    end
  end

  assign o_err_count = r_err_count;
  assign o_err_addr  = r_err_addr;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// ahb_lite_interconnect
// Single-master AHB-Lite interconnect: slot decoder, data-phase response mux
// and a built-in default slave for unmapped slots.
// Ports:
//   HCLK, HRESET      bus clock, asynchronous active-high reset
//   HADDR, HTRANS     master address phase
//   HSEL              one-hot slave select, combinational from HADDR
//   HREADY/HRESP/HRDATA  muxed data-phase response (HREADY also to slaves)
//   S_HREADYOUT/S_HRESP/S_HRDATA  per-slave responses, slave i data at
//                     [i*DATA_WIDTH +: DATA_WIDTH]
//   err_count, err_addr, err_clr  decode-error log and its synchronous clear
// ---------------------------------------------------------------------------
module ahb_lite_interconnect
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SEL_LSB      = 2,
  parameter int SEL_BITS     = 2,
  parameter int NUM_SLAVES   = 2,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  output logic [NUM_SLAVES-1:0]            HSEL,
  output logic                             HREADY,
  output logic                             HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  input  logic [NUM_SLAVES-1:0]            S_HREADYOUT,
  input  logic [NUM_SLAVES-1:0]            S_HRESP,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] S_HRDATA,
  output logic [ERRCNT_WIDTH-1:0]          err_count,
  output logic [ADDR_WIDTH-1:0]            err_addr,
  input  logic                             err_clr
);

  logic [SEL_BITS-1:0]   w_slot;
  logic                  w_mapped;
  logic                  w_active;
  // r_dslot[SEL_BITS] = default-slave flag, low bits = populated slot index.
  logic [SEL_BITS:0]     r_dslot;
  logic [NUM_SLAVES-1:0] w_hit;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_ds_hready;
  logic                  w_ds_hresp;

  assign w_slot   = HADDR[SEL_LSB +: SEL_BITS];
  // Widened compare so NUM_SLAVES == 2**SEL_BITS still works.
  assign w_mapped = ({1'b0, w_slot} < (SEL_BITS+1)'(NUM_SLAVES));
  assign w_active = htrans_active(HTRANS);

  // Address-phase decode: one-hot select of the populated slot, none if unmapped.
  always_comb begin
    HSEL = {NUM_SLAVES{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL[i] = w_mapped & (w_slot == SEL_BITS'(i));
    end
  end

  // Data-phase target: advances only when the current data phase completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dslot <= {1'b1, {SEL_BITS{1'b0}}};
    end else if (HREADY) begin
      r_dslot <= {~w_mapped, w_slot};
    end
  end

  // AND-OR response mux keyed by the registered data-phase slot.
  always_comb begin
    w_hit   = {NUM_SLAVES{1'b0}};
    w_rdata = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_hit[i] = ~r_dslot[SEL_BITS] & (r_dslot[SEL_BITS-1:0] == SEL_BITS'(i));
      w_rdata  = w_rdata | ({DATA_WIDTH{w_hit[i]}} & S_HRDATA[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign HREADY = r_dslot[SEL_BITS] ? w_ds_hready : |(w_hit & S_HREADYOUT);
  assign HRESP  = r_dslot[SEL_BITS] ? w_ds_hresp  : |(w_hit & S_HRESP);
  assign HRDATA = w_rdata;

  ahb_default_slave #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .ERRCNT_WIDTH (ERRCNT_WIDTH)
  ) u_default_slave (
    .i_clk       (HCLK),
    .i_rst       (HRESET),
    .i_hready    (HREADY),
    .i_unmapped  (~w_mapped),
    .i_active    (w_active),
    .i_haddr     (HADDR),
    .i_err_clr   (err_clr),
    .o_hready    (w_ds_hready),
    .o_hresp     (w_ds_hresp),
    .o_err_count (err_count),
    .o_err_addr  (err_addr)
  );

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_interconnect
// Directed bench with hand-computed expectations. Two instances share the
// stimulus: dut (8-bit error counter) and dut_sat (2-bit error counter).
// ---------------------------------------------------------------------------
module tb_ahb_lite_interconnect;
  import ahb_lite_pkg::*;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [1:0]  S_HREADYOUT;
  logic [1:0]  S_HRESP;
  logic [63:0] S_HRDATA;
  logic        err_clr;

  logic [1:0]  hsel;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic [7:0]  err_count;
  logic [31:0] err_addr;

  logic [1:0]  sat_hsel;
  logic        sat_hready;
  logic        sat_hresp;
  logic [31:0] sat_hrdata;
  logic [1:0]  sat_err_count;
  logic [31:0] sat_err_addr;

  int n_pass  = 0;
  int n_total = 0;

  ahb_lite_interconnect #(.ERRCNT_WIDTH(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL(hsel), .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA),
    .err_count(err_count), .err_addr(err_addr), .err_clr(err_clr)
  );

  ahb_lite_interconnect #(.ERRCNT_WIDTH(2)) dut_sat (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL(sat_hsel), .HREADY(sat_hready), .HRESP(sat_hresp), .HRDATA(sat_hrdata),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA),
    .err_count(sat_err_count), .err_addr(sat_err_addr), .err_clr(err_clr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // New address phase 1 ns after the rising edge; checks follow 1 ns later.
  task automatic drive(input logic [31:0] addr, input logic [1:0] trans);
    @(posedge HCLK);
    #1;
    HADDR  = addr;
    HTRANS = trans;
    err_clr = 1'b0;
    #1;
  endtask

  initial begin
    HRESET      = 1'b1;
    HADDR       = 32'h0000_0000;
    HTRANS      = HTRANS_IDLE;
    S_HREADYOUT = 2'b11;
    S_HRESP     = 2'b00;
    S_HRDATA    = {32'h0000_5A5A, 32'hA5A5_0000};
    err_clr     = 1'b0;

    #2;
    chk("rst_hready",    32'(hready),    32'd1);
    chk("rst_hresp",     32'(hresp),     32'd0);
    chk("rst_hrdata",    hrdata,         32'h0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_addr",  err_addr,       32'h0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Pipelined switch: slot0 (one wait state) then slot1
    drive(32'h0000_0000, HTRANS_NONSEQ);
    chk("a_hsel",   32'(hsel),   32'h1);
    chk("a_hready", 32'(hready), 32'd1);
    drive(32'h0000_0004, HTRANS_NONSEQ);
    S_HREADYOUT = 2'b10;
    #1;
    chk("b_hsel",        32'(hsel),   32'h2);
    chk("b_wait_hready", 32'(hready), 32'd0);
    drive(32'h0000_0004, HTRANS_NONSEQ);
    S_HREADYOUT = 2'b11;
    #1;
    chk("c_hready", 32'(hready), 32'd1);
    chk("c_hrdata", hrdata,      32'hA5A5_0000);
    drive(32'h0000_0000, HTRANS_IDLE);
    S_HRESP = 2'b01;
    #1;
    chk("d_hready", 32'(hready), 32'd1);
    chk("d_hresp",  32'(hresp),  32'd0);
    chk("d_hrdata", hrdata,      32'h0000_5A5A);
    S_HRESP = 2'b00;

    // Unmapped NONSEQ to slot3
    drive(32'h0000_000C, HTRANS_NONSEQ);
    chk("e_hsel",   32'(hsel),   32'h0);
    chk("e_hready", 32'(hready), 32'd1);
    drive(32'h0000_0000, HTRANS_IDLE);
    chk("f_err1_hready", 32'(hready), 32'd0);
    chk("f_err1_hresp",  32'(hresp),  32'd1);
    chk("f_err1_hrdata", hrdata,      32'h0);
    drive(32'h0000_0000, HTRANS_IDLE);
    chk("g_err2_hready", 32'(hready),    32'd1);
    chk("g_err2_hresp",  32'(hresp),     32'd1);
    chk("g_err_count",   32'(err_count), 32'd1);
    chk("g_err_addr",    err_addr,       32'h0000_000C);

    // Unmapped IDLE: zero-wait OKAY, no log
    drive(32'h0000_0008, HTRANS_IDLE);
    chk("h_hsel", 32'(hsel), 32'h0);
    drive(32'h0000_0000, HTRANS_IDLE);
    chk("i_hready",    32'(hready),    32'd1);
    chk("i_hresp",     32'(hresp),     32'd0);
    chk("i_hrdata",    hrdata,         32'h0);
    chk("i_err_count", 32'(err_count), 32'd1);
    err_clr = 1'b1;

    // Back-to-back unmapped NONSEQs after a clear
    drive(32'h0000_0008, HTRANS_NONSEQ);
    chk("j_clr_count", 32'(err_count), 32'd0);
    chk("j_clr_addr",  err_addr,       32'h0);
    drive(32'h0000_000C, HTRANS_NONSEQ);
    chk("k_err1_hready", 32'(hready), 32'd0);
    chk("k_err1_hresp",  32'(hresp),  32'd1);
    drive(32'h0000_000C, HTRANS_NONSEQ);
    chk("l_err2_hready", 32'(hready), 32'd1);
    chk("l_err2_hresp",  32'(hresp),  32'd1);
    drive(32'h0000_0000, HTRANS_IDLE);
    chk("m_err1_hready", 32'(hready), 32'd0);
    chk("m_err1_hresp",  32'(hresp),  32'd1);
    drive(32'h0000_0000, HTRANS_IDLE);
    chk("n_err2_hready", 32'(hready),    32'd1);
    chk("n_err2_hresp",  32'(hresp),     32'd1);
    chk("n_err_count",   32'(err_count), 32'd2);
    chk("n_err_addr",    err_addr,       32'h0000_000C);

    // Three more errors: 5 total, 2-bit counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      drive(32'h0000_000C, HTRANS_NONSEQ);
      drive(32'h0000_0000, HTRANS_IDLE);
      drive(32'h0000_0000, HTRANS_IDLE);
    end
    chk("sat8_count", 32'(err_count),     32'd5);
    chk("sat2_count", 32'(sat_err_count), 32'd3);

    // Clear in the same cycle as an error event: clear wins
    drive(32'h0000_0008, HTRANS_NONSEQ);
    err_clr = 1'b1;
    drive(32'h0000_0000, HTRANS_IDLE);
    chk("clr_hready",     32'(hready),        32'd0);
    chk("clr_hresp",      32'(hresp),         32'd1);
    chk("clr_count",      32'(err_count),     32'd0);
    chk("clr_addr",       err_addr,           32'h0);
    chk("clr_sat_count",  32'(sat_err_count), 32'd0);
    drive(32'h0000_0000, HTRANS_IDLE);
    chk("clr_err2_hresp", 32'(hresp),         32'd1);

    // Reset in the middle of an ERROR response
    drive(32'h0000_0000, HTRANS_IDLE);
    drive(32'h0000_000C, HTRANS_NONSEQ);
    drive(32'h0000_0000, HTRANS_IDLE);
    chk("pre_rst_hready", 32'(hready),    32'd0);
    chk("pre_rst_count",  32'(err_count), 32'd1);
    HRESET = 1'b1;
    #1;
    chk("mid_rst_hready", 32'(hready),    32'd1);
    chk("mid_rst_hresp",  32'(hresp),     32'd0);
    chk("mid_rst_hrdata", hrdata,         32'h0);
    chk("mid_rst_count",  32'(err_count), 32'd0);
    chk("mid_rst_addr",   err_addr,       32'h0);
    #1;
    HRESET = 1'b0;
    drive(32'h0000_0004, HTRANS_NONSEQ);
    chk("post_rst_hready", 32'(hready), 32'd1);
    drive(32'h0000_0000, HTRANS_IDLE);
    chk("post_rst_hrdata", hrdata, 32'h0000_5A5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
